// File: rtl/playback_sequencer_pkg.sv
// Shared types and defaults for the playback segment sequencer.
package playback_pkg;

    localparam int unsigned DEF_N_ADDR_BITS  = 20;
    localparam int unsigned DEF_N_SEG        = 8;
    localparam int unsigned DEF_SEG_IDX_BITS = 3;
    localparam int unsigned DEF_REP_BITS     = 8;

    // Segment record field widths at the default configuration.
    localparam int unsigned SEG_START_W = DEF_N_ADDR_BITS;
    localparam int unsigned SEG_STOP_W  = DEF_N_ADDR_BITS;
    localparam int unsigned SEG_REPS_W  = DEF_REP_BITS;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StLoadStart = 3'd1,
        StLoadStop  = 3'd2,
        StPlay      = 3'd3,
        StNext      = 3'd4,
        StDone      = 3'd5
    } seq_state_e;

endpackage

// File: rtl/playback_sequencer_if.sv
// Sequencer-to-RAM-controller link; the sequencer is the master side.
interface playback_sequencer_if #(
    parameter int unsigned N_ADDR_BITS = 20
) ();

    logic [N_ADDR_BITS-1:0] set_ram_addr;
    logic                   write_addr;
    logic [N_ADDR_BITS-1:0] stop_addr;
    logic                   write_stop_addr;
    logic                   playback_en;
    logic                   loop_playback;
    logic                   rp_done;

    modport master (
        output set_ram_addr,
        output write_addr,
        output stop_addr,
        output write_stop_addr,
        output playback_en,
        output loop_playback,
        input  rp_done
    );

    modport slave (
        input  set_ram_addr,
        input  write_addr,
        input  stop_addr,
        input  write_stop_addr,
        input  playback_en,
        input  loop_playback,
        output rp_done
    );

endinterface

// File: rtl/playback_sequencer_sync_edge_det.sv
// Two-flop synchronizer followed by a rising-edge pulse; pulse is one cycle wide.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    // [0],[1] synchronize, [2] holds the previous synchronized value.
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], d};
        end
    end

    assign pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/playback_sequencer.sv
// Walks a small segment table, loading the RAM controller's start/stop addresses
// and enabling playback once per repeat of each segment.
module playback_sequencer
    import playback_pkg::*;
#(
    parameter int unsigned N_ADDR_BITS  = DEF_N_ADDR_BITS,
    parameter int unsigned N_SEG        = DEF_N_SEG,
    parameter int unsigned SEG_IDX_BITS = DEF_SEG_IDX_BITS,
    parameter int unsigned REP_BITS     = DEF_REP_BITS
) (
    input  logic                    s_axi_clk,
    input  logic                    s_axi_reset,
    input  logic                    cfg_we,
    input  logic [SEG_IDX_BITS-1:0] cfg_idx,
    input  logic [N_ADDR_BITS-1:0]  cfg_start,
    input  logic [N_ADDR_BITS-1:0]  cfg_stop,
    input  logic [REP_BITS-1:0]     cfg_reps,
    input  logic [SEG_IDX_BITS:0]   num_segs,
    input  logic                    loop_all,
    input  logic                    seq_start,
    input  logic                    seq_abort,
    playback_sequencer_if.master    ram,
    output logic [SEG_IDX_BITS-1:0] cur_seg,
    output logic [REP_BITS-1:0]     cur_rep,
    output logic                    busy,
    output logic                    seq_done,
    output logic                    err
);

    localparam int unsigned RepW = REP_BITS + 1;
    localparam int unsigned SegW = SEG_IDX_BITS + 1;

    logic [N_ADDR_BITS-1:0] tbl_start [N_SEG];
    logic [N_ADDR_BITS-1:0] tbl_stop  [N_SEG];
    logic [REP_BITS-1:0]    tbl_reps  [N_SEG];

    seq_state_e state_q;
    logic       seq_start_q;
    logic       start_edge;
    logic       done_pulse;
    logic       num_segs_ok;
    logic [RepW-1:0] reps_eff;
    logic [RepW-1:0] rep_nxt;
    logic [SegW-1:0] seg_nxt;
    logic            more_reps;
    logic            more_segs;

    sync_edge_det u_done_sync (
        .clk   (s_axi_clk),
        .rst_n (s_axi_reset),
        .d     (ram.rp_done),
        .pulse (done_pulse)
    );

    always_ff @(posedge s_axi_clk or negedge s_axi_reset) begin
        if (!s_axi_reset) begin
            seq_start_q <= 1'b0;
        end else begin
            seq_start_q <= seq_start;
        end
    end

    assign start_edge  = seq_start & ~seq_start_q;
    assign num_segs_ok = (num_segs != '0) && (32'(num_segs) <= N_SEG);

    always_ff @(posedge s_axi_clk or negedge s_axi_reset) begin
        if (!s_axi_reset) begin
            for (int i = 0; i < N_SEG; i++) begin
                tbl_start[i] <= '0;
                tbl_stop[i]  <= '1;
                tbl_reps[i]  <= REP_BITS'(1);
            end
        end else if (cfg_we && (state_q == StIdle)) begin
            tbl_start[cfg_idx] <= cfg_start;
            tbl_stop[cfg_idx]  <= cfg_stop;
            tbl_reps[cfg_idx]  <= cfg_reps;
        end
    end

    // A programmed repeat count of zero plays the segment once.
    assign reps_eff  = (tbl_reps[cur_seg] == '0) ? RepW'(1) : RepW'(tbl_reps[cur_seg]);
    assign rep_nxt   = RepW'(cur_rep) + RepW'(1);
    assign seg_nxt   = SegW'(cur_seg) + SegW'(1);
    assign more_reps = rep_nxt < reps_eff;
    // num_segs is live here; the N_SEG bound keeps cur_seg inside the table regardless.
    assign more_segs = (seg_nxt < num_segs) && (32'(seg_nxt) < N_SEG);

    always_ff @(posedge s_axi_clk or negedge s_axi_reset) begin
        if (!s_axi_reset) begin
            state_q             <= StIdle;
            ram.set_ram_addr    <= '0;
            ram.write_addr      <= 1'b0;
            ram.stop_addr       <= '1;
            ram.write_stop_addr <= 1'b0;
            ram.playback_en     <= 1'b0;
            cur_seg             <= '0;
            cur_rep             <= '0;
            seq_done            <= 1'b0;
            err                 <= 1'b0;
        end else begin
            ram.write_addr      <= 1'b0;
            ram.write_stop_addr <= 1'b0;
            if (seq_abort) begin
                if (state_q != StIdle) begin
                    state_q         <= StIdle;
                    ram.playback_en <= 1'b0;
                end
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_edge) begin
                            if (num_segs_ok) begin
                                seq_done <= 1'b0;
                                err      <= 1'b0;
                                cur_seg  <= '0;
                                cur_rep  <= '0;
                                state_q  <= StLoadStart;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    StLoadStart: begin
                        ram.set_ram_addr <= tbl_start[cur_seg];
                        ram.write_addr   <= 1'b1;
                        state_q          <= StLoadStop;
                    end
                    StLoadStop: begin
                        ram.stop_addr       <= tbl_stop[cur_seg];
                        ram.write_stop_addr <= 1'b1;
                        state_q             <= StPlay;
                    end
                    StPlay: begin
                        ram.playback_en <= 1'b1;
                        if (done_pulse) begin
                            state_q <= StNext;
                        end
                    end
                    StNext: begin
                        ram.playback_en <= 1'b0;
                        if (more_reps) begin
                            cur_rep <= rep_nxt[REP_BITS-1:0];
                            state_q <= StLoadStart;
                        end else if (more_segs) begin
                            cur_seg <= seg_nxt[SEG_IDX_BITS-1:0];
                            cur_rep <= '0;
                            state_q <= StLoadStart;
                        end else if (loop_all) begin
                            cur_seg <= '0;
                            cur_rep <= '0;
                            state_q <= StLoadStart;
                        end else begin
                            state_q <= StDone;
                        end
                    end
                    StDone: begin
                        seq_done <= 1'b1;
                        state_q  <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign busy              = (state_q != StIdle);
    assign ram.loop_playback = 1'b0;

endmodule
